regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor to the core's general-register file: configurable data width, register count and number of read ports, plus synchronous reset.
- x0 is hardwired to zero, with optional write-to-read bypass.
- Integrated busy-bit scoreboard so the decode stage detects RAW hazards on in-flight destinations.
- Sits between ID (reads, issue) and WB (writes) in the pipelined npc.

Parameters:
ADDR_WIDTH, 5, register index width; register count NREGS = 2**ADDR_WIDTH
DATA_WIDTH, 64, register data width
NUM_RD, 2, number of independent read ports (1..4)
BYPASS, 1, 1 = same-cycle WB write visible on read ports and clears busy on read; 0 = no forwarding

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
wen  input  1  WB write enable
waddr  input  ADDR_WIDTH  WB destination index
wdata  input  DATA_WIDTH  WB write data
raddr  input  NUM_RD*ADDR_WIDTH  read indices; port i = bits [i*ADDR_WIDTH +: ADDR_WIDTH]
rdata  output  NUM_RD*DATA_WIDTH  read data, same packing
rbusy  output  NUM_RD  port i source has an outstanding producer (hazard)
issue_en  input  1  ID issues an instruction that writes issue_rd
issue_rd  input  ADDR_WIDTH  destination of issued instruction
flush  input  1  pipeline flush: clear all busy bits
any_busy  output  1  OR of all busy bits (drain indicator)

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high on rst; polarity and synchronicity are fixed.
- Reset: while rst is high at a rising edge, every register clears to 0 and every busy bit clears to 0. rst overrides wen, issue_en and flush in that cycle.
- Reset outputs: outputs are combinational, so after reset rdata = 0 and rbusy = 0 for all ports, and any_busy = 0.
- Storage: NREGS x DATA_WIDTH array. Write on the rising edge when wen && waddr != 0.
- x0: writes to index 0 are dropped. Reads of index 0 return 0. busy[0] is never set.
- Read: combinational, zero latency. rdata_i = (raddr_i == 0) ? 0 : rf[raddr_i].
- Bypass (BYPASS=1): if wen && waddr == raddr_i && waddr != 0, then rdata_i = wdata in the same cycle.
- Scoreboard, next-state per bit r != 0, priority order:
  - rst -> 0
  - flush -> 0; issue in the same cycle is discarded
  - issue_en && issue_rd == r -> 1; set wins over a simultaneous clear, because the new producer supersedes the old one
  - wen && waddr == r -> 0
  - otherwise hold
- Hazard output:
  - rbusy_i = busy[raddr_i] & ~(BYPASS && wen && waddr == raddr_i), forced 0 when raddr_i == 0.
  - rbusy is combinational from current state. Same-cycle issue_rd does not affect it; ID handles intra-bundle dependence.
- Multiple read ports may address the same register; each is resolved independently and identically.
- Writes with no matching busy bit are legal (no error flag).
- flush does not alter register contents. A WB write in the flush cycle still commits data.
- any_busy is the registered-state OR, excluding bit 0.

Decomposition:
- Shared package regfile_pkg:
  - defaults REG_ADDR_W = 5 and REG_DATA_W = 64
  - constant REG_ZERO = 0
  - localparam helper for NREGS
- Natural sub-module rf_read_port (one per read port, generated NUM_RD times). It performs the index mux, x0 zeroing, bypass select and rbusy computation from the array, busy vector and write bus.
- Top holds the array, the scoreboard register and the update logic.

Test Plan:
- Reset: write 0xDEAD to x5, assert rst 1 cycle, read x5 on port 0 -> rdata = 0, rbusy = 0, any_busy = 0.
- x0: wen=1, waddr=0, wdata=0x1234, issue_en=1, issue_rd=0 -> next cycle raddr=0 gives rdata = 0, rbusy = 0, any_busy = 0.
- Bypass: x7 = 0x11; in one cycle wen=1, waddr=7, wdata=0x22, raddr0=7 -> rdata0 = 0x22 that cycle (0x11 with BYPASS=0); next cycle both configurations read 0x22.
- Scoreboard: issue x3 at cycle 0 -> cycle 1 rbusy for raddr=3 is 1; WB write x3 = 0x99 at cycle 4 -> that cycle rbusy = 0 with BYPASS=1 and rdata = 0x99; cycle 5 busy[3] = 0.
- Simultaneous set/clear: busy[9]=1; same cycle wen on x9 and issue_en with issue_rd=9 -> busy[9] stays 1; a different-port read of x9 shows the new data next cycle.
- Flush: issue x4, x6, x8 -> any_busy = 1; flush together with issue x10 -> next cycle any_busy = 0 and busy[10] = 0; register contents unchanged.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and helpers for the scoreboarded register file.
// Revision 1.0
`default_nettype none

package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 64;
  localparam int REG_ZERO   = 0;
  localparam int REG_NREGS  = 2 ** REG_ADDR_W;

  function automatic int nregs(input int aw);
    return 1 << aw;
  endfunction
endpackage

`default_nettype wire

// File: rtl/rf_read_port.sv
// rf_read_port: one combinational read port with x0 zeroing, WB bypass and hazard flag.
// Revision 1.0
`default_nettype none

module rf_read_port
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int DATA_WIDTH = REG_DATA_W,
  parameter int NREGS      = nregs(ADDR_WIDTH),
  parameter int BYPASS     = 1
) (
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  input  logic [DATA_WIDTH-1:0] rf_i [NREGS],
  input  logic [NREGS-1:0]      busy_i,
  input  logic                  wen_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rbusy_o
);
  logic is_zero;
  logic hit;

  assign is_zero = (raddr_i == ADDR_WIDTH'(REG_ZERO));
  // A matching WB write both supplies the data and retires the hazard this cycle.
  assign hit     = (BYPASS != 0) && wen_i && (waddr_i == raddr_i) && !is_zero;

  always_comb begin
    rdata_o = '0;
    rbusy_o = 1'b0;
    if (!is_zero) begin
      rdata_o = hit ? wdata_i : rf_i[raddr_i];
      rbusy_o = busy_i[raddr_i] & ~hit;
    end
  end
endmodule

`default_nettype wire

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with hardwired x0 and a busy-bit scoreboard.
// Revision 1.0
`default_nettype none

module regfile_sb
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int DATA_WIDTH = REG_DATA_W,
  parameter int NUM_RD     = 2,
  parameter int BYPASS     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wen,
  input  logic [ADDR_WIDTH-1:0]        waddr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
  output logic [NUM_RD-1:0]            rbusy,
  input  logic                         issue_en,
  input  logic [ADDR_WIDTH-1:0]        issue_rd,
  input  logic                         flush,
  output logic                         any_busy
);
  localparam int NREGS = nregs(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] rf_q [NREGS];
  logic [NREGS-1:0]      busy_q;
  logic [NREGS-1:0]      busy_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) rf_q[r] <= '0;
    end else if (wen && (waddr != ADDR_WIDTH'(REG_ZERO))) begin
      rf_q[waddr] <= wdata;
    end
  end

  // Issue is applied after the WB clear so a new producer supersedes the retiring one.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wen)      busy_d[waddr]    = 1'b0;
      if (issue_en) busy_d[issue_rd] = 1'b1;
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign any_busy = |busy_q[NREGS-1:1];

  generate
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      rf_read_port #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NREGS      (NREGS),
        .BYPASS     (BYPASS)
      ) u_rd (
        .raddr_i (raddr[i*ADDR_WIDTH +: ADDR_WIDTH]),
        .rf_i    (rf_q),
        .busy_i  (busy_q),
        .wen_i   (wen),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .rdata_o (rdata[i*DATA_WIDTH +: DATA_WIDTH]),
        .rbusy_o (rbusy[i])
      );
    end
  endgenerate
endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vector bench for regfile_sb, BYPASS=1 and BYPASS=0 side by side.
// Revision 1.0
`default_nettype none

module tb_regfile_sb;
  logic         clk;
  logic         rst;
  logic         wen;
  logic [4:0]   waddr;
  logic [63:0]  wdata;
  logic [9:0]   raddr;
  logic [127:0] rdata_a, rdata_b;
  logic [1:0]   rbusy_a, rbusy_b;
  logic         issue_en;
  logic [4:0]   issue_rd;
  logic         flush;
  logic         any_a, any_b;

  int errors = 0;
  int checks = 0;

  regfile_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(64), .NUM_RD(2), .BYPASS(1)) u_dut_a (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_a), .rbusy(rbusy_a),
    .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush), .any_busy(any_a)
  );

  regfile_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(64), .NUM_RD(2), .BYPASS(0)) u_dut_b (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
    .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush), .any_busy(any_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        wen;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        ie;
    logic [4:0]  ird;
    logic        fl;
    logic [63:0] e_rd0;
    logic [63:0] e_rd1;
    logic [1:0]  e_rb;
    logic        e_any;
    logic [63:0] e_nb0;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    //                rst wen wa  wdata      ra0 ra1 ie ird fl  e_rd0   e_rd1  e_rb   e_any e_nb0
    tv.push_back(vec_t'{0, 1, 5,  64'hDEAD,  5,  0,  0, 0,  0,  64'hDEAD, 0,    2'b00, 0,    0});        // 0 write x5
    tv.push_back(vec_t'{1, 0, 0,  0,         5,  0,  0, 0,  0,  64'hDEAD, 0,    2'b00, 0,    64'hDEAD});// 1 reset
    tv.push_back(vec_t'{0, 0, 0,  0,         5,  0,  0, 0,  0,  0,        0,    2'b00, 0,    0});        // 2 x5 cleared
    tv.push_back(vec_t'{0, 1, 0,  64'h1234,  0,  0,  1, 0,  0,  0,        0,    2'b00, 0,    0});        // 3 x0 write+issue
    tv.push_back(vec_t'{0, 0, 0,  0,         0,  0,  0, 0,  0,  0,        0,    2'b00, 0,    0});        // 4
    tv.push_back(vec_t'{0, 1, 7,  64'h11,    7,  0,  0, 0,  0,  64'h11,   0,    2'b00, 0,    0});        // 5 x7=11
    tv.push_back(vec_t'{0, 1, 7,  64'h22,    7,  7,  0, 0,  0,  64'h22,   64'h22, 2'b00, 0,  64'h11});   // 6 bypass
    tv.push_back(vec_t'{0, 0, 0,  0,         7,  7,  0, 0,  0,  64'h22,   64'h22, 2'b00, 0,  64'h22});   // 7
    tv.push_back(vec_t'{0, 0, 0,  0,         3,  0,  1, 3,  0,  0,        0,    2'b00, 0,    0});        // 8 issue x3
    tv.push_back(vec_t'{0, 0, 0,  0,         3,  3,  0, 0,  0,  0,        0,    2'b11, 1,    0});        // 9
    tv.push_back(vec_t'{0, 0, 0,  0,         3,  0,  0, 0,  0,  0,        0,    2'b01, 1,    0});        // 10
    tv.push_back(vec_t'{0, 1, 3,  64'h99,    3,  3,  0, 0,  0,  64'h99,   64'h99, 2'b00, 1,  0});        // 11 WB x3
    tv.push_back(vec_t'{0, 0, 0,  0,         3,  0,  0, 0,  0,  64'h99,   0,    2'b00, 0,    64'h99});   // 12
    tv.push_back(vec_t'{0, 0, 0,  0,         9,  0,  1, 9,  0,  0,        0,    2'b00, 0,    0});        // 13 issue x9
    tv.push_back(vec_t'{0, 1, 9,  64'hAB,    9,  9,  1, 9,  0,  64'hAB,   64'hAB, 2'b00, 1,  0});        // 14 set+clear
    tv.push_back(vec_t'{0, 0, 0,  0,         0,  9,  0, 0,  0,  0,        64'hAB, 2'b10, 1,  0});        // 15
    tv.push_back(vec_t'{0, 1, 9,  64'hAC,    9,  0,  0, 0,  0,  64'hAC,   0,    2'b00, 1,    64'hAB});   // 16 retire x9
    tv.push_back(vec_t'{0, 0, 0,  0,         3,  0,  1, 4,  0,  64'h99,   0,    2'b00, 0,    64'h99});   // 17 issue x4
    tv.push_back(vec_t'{0, 0, 0,  0,         4,  0,  1, 6,  0,  0,        0,    2'b01, 1,    0});        // 18 issue x6
    tv.push_back(vec_t'{0, 0, 0,  0,         6,  4,  1, 8,  0,  0,        0,    2'b11, 1,    0});        // 19 issue x8
    tv.push_back(vec_t'{0, 1, 12, 64'h55,    8,  10, 1, 10, 1,  0,        0,    2'b01, 1,    0});        // 20 flush+issue+WB
    tv.push_back(vec_t'{0, 0, 0,  0,         3,  12, 0, 0,  0,  64'h99,   64'h55, 2'b00, 0,  64'h99});   // 21
    tv.push_back(vec_t'{0, 0, 0,  0,         10, 9,  0, 0,  0,  0,        64'hAC, 2'b00, 0,  0});        // 22
    tv.push_back(vec_t'{0, 1, 31, ONES,      31, 0,  0, 0,  0,  ONES,     0,    2'b00, 0,    0});        // 23 top index
    tv.push_back(vec_t'{0, 0, 0,  0,         31, 0,  0, 0,  0,  ONES,     0,    2'b00, 0,    ONES});     // 24

    rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0; raddr = {5'd1, 5'd31};
    issue_en = 1'b0; issue_rd = '0; flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("init rdata0", rdata_a[63:0], 64'h0);
    chk("init rdata1", rdata_a[127:64], 64'h0);
    chk("init rbusy", {62'h0, rbusy_a}, 64'h0);
    chk("init any_busy", {63'h0, any_a}, 64'h0);

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      rst      = tv[i].rst;
      wen      = tv[i].wen;
      waddr    = tv[i].waddr;
      wdata    = tv[i].wdata;
      raddr    = {tv[i].ra1, tv[i].ra0};
      issue_en = tv[i].ie;
      issue_rd = tv[i].ird;
      flush    = tv[i].fl;
      #1;
      chk($sformatf("v%0d rdata0", i), rdata_a[63:0], tv[i].e_rd0);
      chk($sformatf("v%0d rdata1", i), rdata_a[127:64], tv[i].e_rd1);
      chk($sformatf("v%0d rbusy", i), {62'h0, rbusy_a}, {62'h0, tv[i].e_rb});
      chk($sformatf("v%0d any_busy", i), {63'h0, any_a}, {63'h0, tv[i].e_any});
      chk($sformatf("v%0d nobyp rdata0", i), rdata_b[63:0], tv[i].e_nb0);
    end

    // Flush with no issue pending must leave contents and an already-idle scoreboard alone.
    @(negedge clk);
    wen = 1'b0; issue_en = 1'b0; flush = 1'b1; raddr = {5'd7, 5'd12};
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("post-flush x12", rdata_a[63:0], 64'h55);
    chk("post-flush x7", rdata_a[127:64], 64'h22);
    chk("post-flush any_busy", {63'h0, any_b}, 64'h0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
